cycle_pattern_detector: RTL and testbench

- Parametrised successor to the fixed single-pattern serial cycle detector.
- Watches a 1-bit serial stream and flags each occurrence of a runtime-programmable bit pattern up to MAX_LEN bits long.
- Supports overlapping or non-overlapping match modes, input qualification, and a saturating match counter.
- Sits between a serial input source and status/interrupt logic.

---
 rtl/cycle_pattern_detector_if.sv | 26 ++
 rtl/cycle_pattern_detector.sv | 58 +++++
 tb/tb_cycle_pattern_detector.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cycle_pattern_detector_if.sv
// cycle_pattern_detector_if: serial input, runtime pattern config and match status for cycle_pattern_detector
//   master: drives in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap; reads detected, match_count, armed
//   slave : the detector side of the same signals
interface cycle_pattern_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    logic               in_valid;
    logic               in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               armed;
    modport master (
        output in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  detected, match_count, armed
    );
    modport slave (
        input  in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output detected, match_count, armed
    );
endinterface

// File: rtl/cycle_pattern_detector.sv
// cycle_pattern_detector: flags each occurrence of a programmable serial bit pattern (up to MAX_LEN bits)
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of cycle_pattern_detector_if (serial input, config strobe/fields, detected/match_count/armed)
module cycle_pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic                     clk,
    input logic                     rst,
    cycle_pattern_detector_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    logic [MAX_LEN-1:0] history, pattern, nh, mask;
    logic [LEN_W-1:0]   len, fill, nfill, load_len;
    logic [CNT_W-1:0]   count;
    logic               overlap, detected, match;
    always_comb begin
        nh       = {history[MAX_LEN-2:0], bus.in};
        nfill    = (fill == LEN_MAX) ? fill : fill + 1'b1;
        load_len = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
        mask     = '0;
        // only the low len bits take part in the compare
        for (int i = 0; i < MAX_LEN; i++) mask[i] = LEN_W'(i) < len;
        match    = (len != '0) && (nfill >= len) && (((nh ^ pattern) & mask) == '0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history  <= '0;
            fill     <= '0;
            count    <= '0;
            detected <= 1'b0;
            pattern  <= '0;
            len      <= '0;
            overlap  <= 1'b1;
        end else if (bus.cfg_load) begin
            pattern  <= bus.cfg_pattern;
            len      <= load_len;
            overlap  <= bus.cfg_overlap;
            history  <= '0;
            fill     <= '0;
            count    <= '0;
            detected <= 1'b0;
        end else begin
            detected <= bus.in_valid && match;
            if (bus.in_valid) begin
                // non-overlap mode restarts the history so the next match needs len fresh bits
                history <= (match && !overlap) ? '0 : nh;
                fill    <= (match && !overlap) ? '0 : nfill;
                if (match && count != '1) count <= count + 1'b1;
            end
        end
    end
    assign bus.detected    = detected;
    assign bus.match_count = count;
    assign bus.armed       = (len != '0) && (fill >= len);
endmodule

// File: tb/tb_cycle_pattern_detector.sv
// tb_cycle_pattern_detector: directed checks of cycle_pattern_detector (8-bit counter and 2-bit saturating counter instances)
module tb_cycle_pattern_detector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    cycle_pattern_detector_if #(.MAX_LEN(8), .CNT_W(8)) a ();
    cycle_pattern_detector_if #(.MAX_LEN(8), .CNT_W(2)) s ();
    cycle_pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    cycle_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut_s (.clk(clk), .rst(rst), .bus(s.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                         input logic ov, input logic v, input logic b);
        @(negedge clk);
        a.cfg_load = ld; a.cfg_pattern = pat; a.cfg_len = len; a.cfg_overlap = ov; a.in_valid = v; a.in = b;
        s.cfg_load = ld; s.cfg_pattern = pat; s.cfg_len = len; s.cfg_overlap = ov; s.in_valid = v; s.in = b;
        @(posedge clk);
        #1;
        a.cfg_load = 1'b0; a.in_valid = 1'b0;
        s.cfg_load = 1'b0; s.in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        drive(1'b1, pat, len, ov, 1'b0, 1'b0);
    endtask

    task automatic bit_in(input logic b);
        drive(1'b0, 8'hA5, 4'd0, 1'b0, 1'b1, b);
    endtask

    task automatic idle();
        drive(1'b0, 8'h5A, 4'd7, 1'b0, 1'b0, 1'b1);
    endtask

    logic [6:0] t1_bits = 7'b1011011;
    logic [6:0] t1_det  = 7'b0001001;
    logic [6:0] t2_det  = 7'b0001000;
    logic [7:0] t5_pat  = 8'b10110011;

    initial begin
        a.cfg_load = 0; a.cfg_pattern = 0; a.cfg_len = 0; a.cfg_overlap = 0; a.in_valid = 0; a.in = 0;
        s.cfg_load = 0; s.cfg_pattern = 0; s.cfg_len = 0; s.cfg_overlap = 0; s.in_valid = 0; s.in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_detected", a.detected, 0);
        chk("reset_count", a.match_count, 0);
        chk("reset_armed", a.armed, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: overlapping 1011 over 1,0,1,1,0,1,1
        load(8'b1011, 4'd4, 1'b1);
        for (int i = 6; i >= 0; i--) begin
            bit_in(t1_bits[i]);
            chk($sformatf("ovl_det_%0d", 6 - i), a.detected, t1_det[i]);
        end
        chk("ovl_count", a.match_count, 2);
        chk("ovl_armed", a.armed, 1);

        // 2: same stream, non-overlapping
        load(8'b1011, 4'd4, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            bit_in(t1_bits[i]);
            chk($sformatf("novl_det_%0d", 6 - i), a.detected, t2_det[i]);
            if (i == 3) chk("novl_armed_after_match", a.armed, 0);
        end
        chk("novl_count", a.match_count, 1);

        // 3: in_valid gaps do not break a match in progress
        load(8'b110, 4'd3, 1'b1);
        bit_in(1'b1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("gap_det_%0d", i), a.detected, 0);
        end
        bit_in(1'b1);
        chk("gap_det_pre", a.detected, 0);
        bit_in(1'b0);
        chk("gap_det_hit", a.detected, 1);
        idle();
        chk("gap_det_pulse_end", a.detected, 0);
        chk("gap_count", a.match_count, 1);

        // 4: saturation of the 2-bit counter
        load(8'b01, 4'd2, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            bit_in(1'b0);
            chk($sformatf("sat_det0_%0d", k), s.detected, 0);
            bit_in(1'b1);
            chk($sformatf("sat_det1_%0d", k), s.detected, 1);
            chk($sformatf("sat_count_%0d", k), s.match_count, (k > 3) ? 3 : k);
        end
        chk("sat_wide_count", a.match_count, 5);

        // 5a: reset mid-pattern
        load(8'b1011, 4'd4, 1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_armed", a.armed, 0);
        chk("rst_async_count", a.match_count, 0);
        @(negedge clk);
        rst = 1'b1;
        bit_in(1'b1);
        chk("rst_det", a.detected, 0);
        chk("rst_count", a.match_count, 0);

        // 5b: len 0 disables detection
        load(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            bit_in(1'($urandom_range(0, 1)));
            chk($sformatf("len0_det_%0d", i), a.detected, 0);
        end
        chk("len0_armed", a.armed, 0);
        chk("len0_count", a.match_count, 0);

        // 5c: len 12 clamps to 8
        load(t5_pat, 4'd12, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) chk("clamp_armed_pre", a.armed, 0);
            bit_in(t5_pat[i]);
            chk($sformatf("clamp_det_%0d", 7 - i), a.detected, i == 0);
        end
        chk("clamp_armed", a.armed, 1);
        chk("clamp_count", a.match_count, 1);

        // 6: cfg_load wins over in_valid in the same cycle
        load(8'b01, 4'd2, 1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("prio_setup_count", a.match_count, 1);
        bit_in(1'b0);
        drive(1'b1, 8'b01, 4'd2, 1'b1, 1'b1, 1'b1);
        chk("prio_det", a.detected, 0);
        chk("prio_count", a.match_count, 0);
        chk("prio_armed", a.armed, 0);
        bit_in(1'b1);
        chk("prio_hist_clear", a.detected, 0);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("prio_after_det", a.detected, 1);
        chk("prio_after_count", a.match_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
